// File: rtl/sound_pkg.sv
// Shared types and constants for the piezo sound scheduler: source codes, FSM states,
// note frequencies and the fixed-priority request encoder.
package sound_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StTone,
        StGap
    } state_e;

    localparam logic [1:0] SRC_CLICK = 2'd0;
    localparam logic [1:0] SRC_BONO  = 2'd1;
    localparam logic [1:0] SRC_WIN   = 2'd2;
    localparam logic [1:0] SRC_LOSE  = 2'd3;

    localparam int unsigned MAX_NOTES = 4;
    localparam int unsigned IDX_W     = $clog2(MAX_NOTES);

    localparam int unsigned F_C4 = 262;
    localparam int unsigned F_E4 = 330;
    localparam int unsigned F_G4 = 392;
    localparam int unsigned F_C5 = 523;
    localparam int unsigned F_E5 = 659;
    localparam int unsigned F_G5 = 784;
    localparam int unsigned F_C6 = 1047;
    localparam int unsigned F_E6 = 1319;
    localparam int unsigned F_G6 = 1568;

    // req bit order: {lose, win, bono, click}; caller qualifies with |req.
    function automatic logic [1:0] top_src(input logic [3:0] req);
        if (req[3]) return SRC_LOSE;
        if (req[2]) return SRC_WIN;
        if (req[1]) return SRC_BONO;
        return SRC_CLICK;
    endfunction

endpackage

// File: rtl/rom_melodias.sv
// Combinational note table: {half_period, dur_ms, last} for each (source, note index).
module rom_melodias
    import sound_pkg::*;
#(
    parameter int unsigned CLK_HZ   = 50_000_000,
    parameter int unsigned NOTE_MS  = 100,
    parameter int unsigned CLICK_MS = 30
) (
    input  logic [1:0]       src,
    input  logic [IDX_W-1:0] idx,
    output logic [16:0]      half_period,
    output logic [15:0]      dur_ms,
    output logic             last
);

    function automatic logic [16:0] hp(input int unsigned f);
        return 17'(CLK_HZ / (2 * f));
    endfunction

    always_comb begin
        half_period = '0;
        dur_ms      = 16'(NOTE_MS);
        last        = 1'b1;
        case (src)
            SRC_CLICK: begin
                half_period = hp(F_C6);
                dur_ms      = 16'(CLICK_MS);
            end
            SRC_BONO: begin
                case (idx)
                    2'd0: begin
                        half_period = hp(F_E6);
                        last        = 1'b0;
                    end
                    default: half_period = hp(F_G6);
                endcase
            end
            SRC_WIN: begin
                case (idx)
                    2'd0: begin
                        half_period = hp(F_C5);
                        last        = 1'b0;
                    end
                    2'd1: begin
                        half_period = hp(F_E5);
                        last        = 1'b0;
                    end
                    2'd2: begin
                        half_period = hp(F_G5);
                        last        = 1'b0;
                    end
                    default: half_period = hp(F_C6);
                endcase
            end
            default: begin
                dur_ms = 16'(2 * NOTE_MS);
                case (idx)
                    2'd0: begin
                        half_period = hp(F_G4);
                        last        = 1'b0;
                    end
                    2'd1: begin
                        half_period = hp(F_E4);
                        last        = 1'b0;
                    end
                    default: half_period = hp(F_C4);
                endcase
            end
        endcase
    end

endmodule

// File: rtl/sound_scheduler.sv
// Fixed-priority arbiter and note sequencer driving the single piezo output with a
// registered square wave.
module sound_scheduler
    import sound_pkg::*;
#(
    parameter int unsigned CLK_HZ   = 50_000_000,
    parameter int unsigned NOTE_MS  = 100,
    parameter int unsigned CLICK_MS = 30,
    parameter int unsigned GAP_MS   = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_click,
    input  logic       req_bono,
    input  logic       req_win,
    input  logic       req_lose,
    input  logic       mute,
    output logic       busy,
    output logic [1:0] active_src,
    output logic       buzzer
);

    localparam int unsigned MS_CYC = CLK_HZ / 1000;
    localparam int unsigned PS_W   = (MS_CYC > 1) ? $clog2(MS_CYC) : 1;

    state_e           state_q, state_d;
    logic [1:0]       src_q, src_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [PS_W-1:0]  ps_q, ps_d;
    logic [16:0]      hp_q, hp_d, tone_q, tone_d;
    logic [15:0]      dur_ms_q, dur_ms_d, dur_q, dur_d, gap_q, gap_d;
    logic             last_q, last_d, raw_q, raw_d, buzzer_q, buzzer_d;

    logic        ms_tick;
    logic [3:0]  req;
    logic [1:0]  req_src;
    logic        req_any;
    logic [16:0] rom_hp;
    logic [15:0] rom_dur;
    logic        rom_last;

    rom_melodias #(
        .CLK_HZ  (CLK_HZ),
        .NOTE_MS (NOTE_MS),
        .CLICK_MS(CLICK_MS)
    ) u_rom (
        .src        (src_q),
        .idx        (idx_q),
        .half_period(rom_hp),
        .dur_ms     (rom_dur),
        .last       (rom_last)
    );

    assign req     = {req_lose, req_win, req_bono, req_click};
    assign req_any = |req;
    assign req_src = top_src(req);
    assign ms_tick = (ps_q == PS_W'(MS_CYC - 1));

    always_comb begin
        state_d  = state_q;
        src_d    = src_q;
        idx_d    = idx_q;
        hp_d     = hp_q;
        dur_ms_d = dur_ms_q;
        last_d   = last_q;
        tone_d   = tone_q;
        dur_d    = dur_q;
        gap_d    = gap_q;
        raw_d    = raw_q;
        ps_d     = ms_tick ? '0 : ps_q + PS_W'(1);

        unique case (state_q)
            StIdle: begin
                raw_d = 1'b0;
                if (req_any) begin
                    src_d   = req_src;
                    idx_d   = '0;
                    state_d = StLoad;
                end
            end
            StLoad: begin
                hp_d     = rom_hp;
                dur_ms_d = rom_dur;
                last_d   = rom_last;
                tone_d   = '0;
                dur_d    = '0;
                state_d  = StTone;
            end
            StTone: begin
                if (hp_q == '0) begin
                    raw_d = 1'b0;
                end else if (tone_q == hp_q - 17'd1) begin
                    tone_d = '0;
                    raw_d  = ~raw_q;
                end else begin
                    tone_d = tone_q + 17'd1;
                end
                if (ms_tick) begin
                    if (dur_q == dur_ms_q - 16'd1) begin
                        gap_d   = '0;
                        raw_d   = 1'b0;
                        state_d = StGap;
                    end else begin
                        dur_d = dur_q + 16'd1;
                    end
                end
            end
            StGap: begin
                raw_d = 1'b0;
                if (ms_tick) begin
                    if (gap_q == 16'(GAP_MS - 1)) begin
                        if (last_q) begin
                            state_d = StIdle;
                        end else begin
                            idx_d   = idx_q + IDX_W'(1);
                            state_d = StLoad;
                        end
                    end else begin
                        gap_d = gap_q + 16'd1;
                    end
                end
            end
        endcase

        // A strictly higher-priority source restarts from its first note; others are dropped.
        if (state_q != StIdle && req_any && req_src > src_q) begin
            src_d   = req_src;
            idx_d   = '0;
            raw_d   = 1'b0;
            state_d = StLoad;
        end

        buzzer_d = raw_d & ~mute;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            src_q    <= SRC_CLICK;
            idx_q    <= '0;
            ps_q     <= '0;
            hp_q     <= '0;
            dur_ms_q <= '0;
            last_q   <= 1'b0;
            tone_q   <= '0;
            dur_q    <= '0;
            gap_q    <= '0;
            raw_q    <= 1'b0;
            buzzer_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            src_q    <= src_d;
            idx_q    <= idx_d;
            ps_q     <= ps_d;
            hp_q     <= hp_d;
            dur_ms_q <= dur_ms_d;
            last_q   <= last_d;
            tone_q   <= tone_d;
            dur_q    <= dur_d;
            gap_q    <= gap_d;
            raw_q    <= raw_d;
            buzzer_q <= buzzer_d;
        end
    end

    assign busy       = (state_q != StIdle);
    assign active_src = busy ? src_q : SRC_CLICK;
    assign buzzer     = buzzer_q;

endmodule
